divider_seq: RTL and testbench

- Iterative radix-2 restoring divider that produces quotient and remainder.
- Parametrised in WIDTH; computes one quotient bit per clock.
- Uses a start/busy/done handshake so it can be shared by a controller or ALU without a large combinational array.
- Handles divide-by-zero explicitly. Signed operation is available as a compile-time option.

---
 rtl/divider_seq.sv | 124 ++++++++++++
 tb/tb_divider_seq.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/divider_seq.sv
// divider_seq: iterative radix-2 restoring divider, one quotient bit per clock.
// Define DIVIDER_SEQ_SIGNED_EN to add the signed_op port and two's-complement operation.
module divider_seq #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
`ifdef DIVIDER_SEQ_SIGNED_EN
    input  logic             signed_op,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned CntW = $clog2(WIDTH);

    typedef enum logic [1:0] {StIdle, StRun, StFinish} state_e;

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q;
    logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
    logic             dz_q;
    logic [WIDTH:0]   shifted, diff;
    logic [WIDTH-1:0] dvd_mag, dvs_mag, quo_fix, rem_fix;
    logic             accept;

    assign accept = (state_q == StIdle) && start;
    assign busy   = (state_q != StIdle);

`ifdef DIVIDER_SEQ_SIGNED_EN
    logic dvd_neg, dvs_neg, neg_quo_q, neg_rem_q;

    always_comb begin
        dvd_neg = signed_op & dividend[WIDTH-1];
        dvs_neg = signed_op & divisor[WIDTH-1];
        dvd_mag = dvd_neg ? -dividend : dividend;
        dvs_mag = dvs_neg ? -divisor : divisor;
        quo_fix = neg_quo_q ? -quo_q : quo_q;
        // Remainder follows the dividend sign; with a zero divisor this restores the dividend.
        rem_fix = neg_rem_q ? -rem_q : rem_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else if (accept) begin
            neg_quo_q <= dvd_neg ^ dvs_neg;
            neg_rem_q <= dvd_neg;
        end
    end
`else
    always_comb begin
        dvd_mag = dividend;
        dvs_mag = divisor;
        quo_fix = quo_q;
        rem_fix = rem_q;
    end
`endif

    // quo_q shifts dividend bits out of its MSB while quotient bits enter at the LSB.
    always_comb begin
        shifted = {rem_q, quo_q[WIDTH-1]};
        diff    = shifted - {1'b0, dvs_q};
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:   if (start) state_d = StRun;
            StRun:    if (cnt_q == CntW'(WIDTH - 1)) state_d = StFinish;
            StFinish: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            dz_q        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            state_q <= state_d;
            done    <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        cnt_q <= '0;
                        rem_q <= '0;
                        quo_q <= dvd_mag;
                        dvs_q <= dvs_mag;
                        dz_q  <= (divisor == '0);
                    end
                end
                StRun: begin
                    cnt_q <= cnt_q + 1'b1;
                    rem_q <= diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
                    quo_q <= {quo_q[WIDTH-2:0], ~diff[WIDTH]};
                end
                StFinish: begin
                    quotient    <= dz_q ? '1 : quo_fix;
                    remainder   <= rem_fix;
                    div_by_zero <= dz_q;
                    done        <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_divider_seq.sv
// tb_divider_seq: randomized and directed checks of divider_seq at WIDTH=8 and WIDTH=16
// against an arithmetic reference model.
module tb_divider_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       start8 = 1'b0;
    logic [7:0] dvd8 = '0, dvs8 = '0;
    logic       busy8, done8, dz8;
    logic [7:0] q8, r8;
`ifdef DIVIDER_SEQ_SIGNED_EN
    logic       sg8 = 1'b0;
`endif

    logic        start16 = 1'b0;
    logic [15:0] dvd16 = '0, dvs16 = '0;
    logic        busy16, done16, dz16;
    logic [15:0] q16, r16;

    int n_checks = 0;
    int n_pass   = 0;

    divider_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .dividend(dvd8), .divisor(dvs8),
`ifdef DIVIDER_SEQ_SIGNED_EN
        .signed_op(sg8),
`endif
        .busy(busy8), .done(done8), .quotient(q8), .remainder(r8), .div_by_zero(dz8)
    );

    divider_seq #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .dividend(dvd16), .divisor(dvs16),
`ifdef DIVIDER_SEQ_SIGNED_EN
        .signed_op(1'b0),
`endif
        .busy(busy16), .done(done16), .quotient(q16), .remainder(r16), .div_by_zero(dz16)
    );

    // Reference: plain integer division; SV longint '/' and '%' truncate toward zero.
    function automatic void model(input int w, input longint a, input longint b, input bit sgn,
                                  output longint q, output longint r, output bit dz);
        longint m, sa, sb;
        m  = (longint'(1) << w) - 1;
        dz = (b == 0);
        if (dz) begin
            q = m;
            r = a;
        end else if (!sgn) begin
            q = a / b;
            r = a % b;
        end else begin
            sa = (a >= (longint'(1) << (w - 1))) ? a - (longint'(1) << w) : a;
            sb = (b >= (longint'(1) << (w - 1))) ? b - (longint'(1) << w) : b;
            q  = sa / sb;
            r  = sa % sb;
        end
        q = q & m;
        r = r & m;
    endfunction

    // Launch one operation; lat = edges from accept to done (-1 on timeout).
    task automatic do_op8(input logic [7:0] a, input logic [7:0] b, output int lat, output bit bok);
        @(negedge clk);
        start8 = 1'b1; dvd8 = a; dvs8 = b;
        @(posedge clk); #1;
        bok = (busy8 === 1'b1);
        start8 = 1'b0; dvd8 = 8'($urandom); dvs8 = 8'($urandom);
        lat = -1;
        for (int i = 1; i <= 40 && lat < 0; i++) begin
            @(posedge clk); #1;
            if (done8 === 1'b1) begin
                lat = i;
                if (busy8 !== 1'b0) bok = 1'b0;
            end else if (busy8 !== 1'b1) bok = 1'b0;
        end
    endtask

    task automatic do_op16(input logic [15:0] a, input logic [15:0] b, output int lat);
        @(negedge clk);
        start16 = 1'b1; dvd16 = a; dvs16 = b;
        @(posedge clk); #1;
        start16 = 1'b0; dvd16 = 16'($urandom); dvs16 = 16'($urandom);
        lat = -1;
        for (int i = 1; i <= 60 && lat < 0; i++) begin
            @(posedge clk); #1;
            if (done16 === 1'b1) lat = i;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks++;
        if ({busy8, done8, q8, r8, dz8} !== 19'd0)
            $display("FAIL reset8: got busy=%b done=%b q=%h r=%h dz=%b, expected all 0",
                     busy8, done8, q8, r8, dz8);
        else n_pass++;
        n_checks++;
        if ({busy16, done16, q16, r16, dz16} !== 35'd0)
            $display("FAIL reset16: got busy=%b done=%b q=%h r=%h dz=%b, expected all 0",
                     busy16, done16, q16, r16, dz16);
        else n_pass++;
    endtask

    task automatic test_unsigned(input int n_rand);
        logic [7:0] ta [7] = '{8'd200, 8'd5, 8'd9, 8'd0, 8'd255, 8'd255, 8'd1};
        logic [7:0] tb [7] = '{8'd7, 8'd0, 8'd3, 8'd5, 8'd1, 8'd255, 8'd255};
        logic [7:0] a, b;
        longint eq, er;
        bit edz, bok;
        int lat;
`ifdef DIVIDER_SEQ_SIGNED_EN
        sg8 = 1'b0;
`endif
        for (int i = 0; i < 7 + n_rand; i++) begin
            if (i < 7) begin
                a = ta[i]; b = tb[i];
            end else begin
                a = 8'($urandom);
                b = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom);
            end
            model(8, longint'(a), longint'(b), 1'b0, eq, er, edz);
            do_op8(a, b, lat, bok);
            n_checks++;
            if (lat != 9 || !bok)
                $display("FAIL timing_u %0d/%0d: got lat=%0d busy_ok=%0b, expected lat=9 busy_ok=1",
                         a, b, lat, bok);
            else n_pass++;
            n_checks++;
            if ({q8, r8, dz8} !== {eq[7:0], er[7:0], edz})
                $display("FAIL result_u %0d/%0d: got q=%h r=%h dz=%b, expected q=%h r=%h dz=%b",
                         a, b, q8, r8, dz8, eq[7:0], er[7:0], edz);
            else n_pass++;
        end
    endtask

`ifdef DIVIDER_SEQ_SIGNED_EN
    task automatic test_signed(input int n_rand);
        logic [7:0] ta [6] = '{8'hF9, 8'h07, 8'h80, 8'h80, 8'hF9, 8'h7F};
        logic [7:0] tb [6] = '{8'h02, 8'hFE, 8'hFF, 8'h00, 8'h00, 8'h80};
        logic [7:0] a, b;
        longint eq, er;
        bit edz, bok, sgn;
        int lat;
        for (int i = 0; i < 6 + n_rand; i++) begin
            if (i < 6) begin
                a = ta[i]; b = tb[i]; sgn = 1'b1;
            end else begin
                a = 8'($urandom);
                b = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom);
                sgn = 1'($urandom);
            end
            sg8 = sgn;
            model(8, longint'(a), longint'(b), sgn, eq, er, edz);
            do_op8(a, b, lat, bok);
            n_checks++;
            if ({lat == 9, bok, q8, r8, dz8} !== {2'b11, eq[7:0], er[7:0], edz})
                $display("FAIL result_s %h/%h sg=%b: got lat=%0d q=%h r=%h dz=%b, expected lat=9 q=%h r=%h dz=%b",
                         a, b, sgn, lat, q8, r8, dz8, eq[7:0], er[7:0], edz);
            else n_pass++;
        end
        sg8 = 1'b0;
    endtask
`endif

    // start held high through busy: operands changed mid-run are ignored, then the
    // still-asserted start is accepted on the edge after done.
    task automatic test_back_to_back();
        int lat1, lat2;
        bit bok;
        @(negedge clk);
        start8 = 1'b1; dvd8 = 8'd100; dvs8 = 8'd9;
        @(posedge clk); #1;
        dvd8 = 8'd77; dvs8 = 8'd5;
        lat1 = -1;
        for (int i = 1; i <= 40 && lat1 < 0; i++) begin
            @(posedge clk); #1;
            if (done8 === 1'b1) lat1 = i;
        end
        n_checks++;
        if (lat1 != 9 || {q8, r8, dz8} !== {8'd11, 8'd1, 1'b0})
            $display("FAIL held_start: got lat=%0d q=%0d r=%0d dz=%b, expected lat=9 q=11 r=1 dz=0",
                     lat1, q8, r8, dz8);
        else n_pass++;
        @(posedge clk); #1;
        bok = (busy8 === 1'b1);
        start8 = 1'b0;
        lat2 = -1;
        for (int i = 1; i <= 40 && lat2 < 0; i++) begin
            @(posedge clk); #1;
            if (done8 === 1'b1) lat2 = i;
        end
        n_checks++;
        if (!bok || lat2 != 9 || {q8, r8, dz8} !== {8'd15, 8'd2, 1'b0})
            $display("FAIL back_to_back: got busy_ok=%0b lat=%0d q=%0d r=%0d dz=%b, expected busy_ok=1 lat=9 q=15 r=2 dz=0",
                     bok, lat2, q8, r8, dz8);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int lat;
        bit bok, seen;
        @(negedge clk);
        start8 = 1'b1; dvd8 = 8'd50; dvs8 = 8'd3;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        n_checks++;
        if ({busy8, done8, q8, r8, dz8} !== 19'd0)
            $display("FAIL reset_mid: got busy=%b done=%b q=%h r=%h dz=%b, expected all 0",
                     busy8, done8, q8, r8, dz8);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (15) begin
            @(posedge clk); #1;
            if (done8 !== 1'b0 || busy8 !== 1'b0) seen = 1'b1;
        end
        n_checks++;
        if (seen)
            $display("FAIL no_done_after_reset: got activity=1, expected activity=0");
        else n_pass++;
        do_op8(8'd123, 8'd10, lat, bok);
        n_checks++;
        if (lat != 9 || !bok || {q8, r8, dz8} !== {8'd12, 8'd3, 1'b0})
            $display("FAIL after_reset: got lat=%0d busy_ok=%0b q=%0d r=%0d dz=%b, expected lat=9 busy_ok=1 q=12 r=3 dz=0",
                     lat, bok, q8, r8, dz8);
        else n_pass++;
    endtask

    task automatic test_wide(input int n_rand);
        logic [15:0] a, b;
        longint eq, er;
        bit edz;
        int lat;
        for (int i = 0; i < 3 + n_rand; i++) begin
            case (i)
                0: begin a = 16'hFFFF; b = 16'h0001; end
                1: begin a = 16'h0003; b = 16'h0010; end
                2: begin a = 16'h1234; b = 16'h0000; end
                default: begin a = 16'($urandom); b = 16'($urandom_range(0, 700)); end
            endcase
            model(16, longint'(a), longint'(b), 1'b0, eq, er, edz);
            do_op16(a, b, lat);
            n_checks++;
            if (lat != 17 || {q16, r16, dz16} !== {eq[15:0], er[15:0], edz})
                $display("FAIL wide %h/%h: got lat=%0d q=%h r=%h dz=%b, expected lat=17 q=%h r=%h dz=%b",
                         a, b, lat, q16, r16, dz16, eq[15:0], er[15:0], edz);
            else n_pass++;
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_unsigned(25);
`ifdef DIVIDER_SEQ_SIGNED_EN
        test_signed(25);
`endif
        test_back_to_back();
        test_reset_mid();
        test_wide(10);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
